// File: rtl/calc_g_scan.sv
// Coordinate sequencer for the G(m,n) calculator: sweeps an N x N grid of signed (m,n) per frame and
// delays valid/addr/last to line up with the calculator output. Define CALC_G_SCAN_FFTSHIFT_EN for FFT order.
module calc_g_scan #(
    parameter int N_LOG2   = 9,
    parameter int CALC_LAT = 6,
    parameter int ADDR_W   = 2 * N_LOG2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       zparam_in,
    output logic [9:0]        m,
    output logic [9:0]        n,
    output logic [31:0]       zparam,
    output logic              issue_valid,
    output logic              g_valid,
    output logic [ADDR_W-1:0] g_addr,
    output logic              g_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int                DW        = $clog2(CALC_LAT + 1);
    localparam logic [DW-1:0]     DRAIN_END = DW'(CALC_LAT - 1);
    localparam logic [N_LOG2-1:0] CNT_MAX   = {N_LOG2{1'b1}};
`ifndef CALC_G_SCAN_FFTSHIFT_EN
    localparam logic [10:0]       HALF      = 11'(1 << (N_LOG2 - 1));
`endif

    // Grid index to signed 10-bit coordinate; the centered form subtracts N/2 at 11 bits.
    function automatic logic [9:0] map_coord(input logic [N_LOG2-1:0] c);
        logic [10:0] w;
`ifdef CALC_G_SCAN_FFTSHIFT_EN
        w = {{(11 - N_LOG2){c[N_LOG2-1]}}, c};
`else
        w = {{(11 - N_LOG2){1'b0}}, c} - HALF;
`endif
        return w[9:0];
    endfunction

    state_t            state_r, state_s;
    logic [N_LOG2-1:0] row_r, col_r, row_s, col_s;
    logic [DW-1:0]     drain_cnt_r, drain_cnt_s;
    logic              issue_s;
    logic              accept_s;
    logic [ADDR_W-1:0] issue_addr_r;
    logic              issue_last_r;

    logic              pipe_valid_r [CALC_LAT];
    logic [ADDR_W-1:0] pipe_addr_r  [CALC_LAT];
    logic              pipe_last_r  [CALC_LAT];

    // Next-state logic; counters always hold the coordinate being issued in the current cycle.
    always_comb begin
        state_s     = state_r;
        row_s       = row_r;
        col_s       = col_r;
        drain_cnt_s = drain_cnt_r;
        issue_s     = 1'b0;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = ST_RUN;
                    row_s    = {N_LOG2{1'b0}};
                    col_s    = {N_LOG2{1'b0}};
                    issue_s  = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (row_r == CNT_MAX && col_r == CNT_MAX) begin
                    state_s     = ST_DRAIN;
                    drain_cnt_s = {DW{1'b0}};
                end else begin
                    issue_s = 1'b1;
                    if (col_r == CNT_MAX) begin
                        col_s = {N_LOG2{1'b0}};
                        row_s = row_r + {{(N_LOG2 - 1){1'b0}}, 1'b1};
                    end else begin
                        col_s = col_r + {{(N_LOG2 - 1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_END) begin
                    state_s = ST_DONE;
                end else begin
                    drain_cnt_s = drain_cnt_r + {{(DW - 1){1'b0}}, 1'b1};
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, counters and registered issue-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            row_r        <= {N_LOG2{1'b0}};
            col_r        <= {N_LOG2{1'b0}};
            drain_cnt_r  <= {DW{1'b0}};
            zparam       <= 32'd0;
            issue_valid  <= 1'b0;
            m            <= 10'd0;
            n            <= 10'd0;
            issue_addr_r <= {ADDR_W{1'b0}};
            issue_last_r <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_r      <= state_s;
            row_r        <= row_s;
            col_r        <= col_s;
            drain_cnt_r  <= drain_cnt_s;
            if (accept_s) begin
                zparam <= zparam_in;
            end
            issue_valid  <= issue_s;
            m            <= issue_s ? map_coord(row_s) : 10'd0;
            n            <= issue_s ? map_coord(col_s) : 10'd0;
            issue_addr_r <= issue_s ? ADDR_W'({row_s, col_s}) : {ADDR_W{1'b0}};
            issue_last_r <= issue_s && (row_s == CNT_MAX) && (col_s == CNT_MAX);
            busy         <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
            done         <= (state_s == ST_DONE);
        end
    end

    // Latency-matching delay line from the issue registers to the calculator output timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CALC_LAT; i++) begin
                pipe_valid_r[i] <= 1'b0;
                pipe_addr_r[i]  <= {ADDR_W{1'b0}};
                pipe_last_r[i]  <= 1'b0;
            end
        end else begin
            pipe_valid_r[0] <= issue_valid;
            pipe_addr_r[0]  <= issue_addr_r;
            pipe_last_r[0]  <= issue_last_r;
            for (int i = 1; i < CALC_LAT; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_addr_r[i]  <= pipe_addr_r[i-1];
                pipe_last_r[i]  <= pipe_last_r[i-1];
            end
        end
    end

    assign g_valid = pipe_valid_r[CALC_LAT-1];
    assign g_addr  = pipe_addr_r[CALC_LAT-1];
    assign g_last  = pipe_last_r[CALC_LAT-1];

endmodule

// File: tb/tb_calc_g_scan.sv
// Randomized self-checking bench for calc_g_scan (N_LOG2=2, CALC_LAT=3) against a frame-timing model.
// Honours CALC_G_SCAN_FFTSHIFT_EN in the reference coordinate mapping.
module tb_calc_g_scan;

    localparam int N_LOG2 = 2;
    localparam int LAT    = 3;
    localparam int N      = 1 << N_LOG2;
    localparam int NN     = N * N;
    localparam int AW     = 2 * N_LOG2;
    localparam int VW     = 57 + AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   zparam_in;
    logic [9:0]    m, n;
    logic [31:0]   zparam;
    logic          issue_valid, g_valid, g_last, busy, done;
    logic [AW-1:0] g_addr;

    int vectors = 0;
    int miscompares = 0;

    calc_g_scan #(.N_LOG2(N_LOG2), .CALC_LAT(LAT), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .zparam_in(zparam_in),
        .m(m), .n(n), .zparam(zparam), .issue_valid(issue_valid),
        .g_valid(g_valid), .g_addr(g_addr), .g_last(g_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Signed coordinate for a grid index.
    function automatic int coord(input int idx);
`ifdef CALC_G_SCAN_FFTSHIFT_EN
        return (idx >= N / 2) ? idx - N : idx;
`else
        return idx - N / 2;
`endif
    endfunction

    function automatic logic [VW-1:0] observed();
        return {issue_valid, m, n, zparam, g_valid, (g_valid ? g_addr : {AW{1'b0}}), g_last, busy, done};
    endfunction

    task automatic test_reset();
        logic [VW-1:0] obs, expv;
        rst = 1'b1; start = 1'b0; zparam_in = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs  = observed();
        expv = '0;
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL reset_values got=%h want=%h", obs, expv);
        end
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int cnt, input logic [31:0] zp);
        logic [VW-1:0] obs, expv;
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            obs  = observed();
            expv = {1'b0, 10'd0, 10'd0, zp, 1'b0, {AW{1'b0}}, 1'b0, 1'b0, 1'b0};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL idle t=%0t got=%h want=%h", $time, obs, expv);
            end
            start = 1'b0;
            zparam_in = $urandom;
        end
    endtask

    // One frame; called at a negedge. ign_at/rst_at are frame-relative cycles (0 = none).
    task automatic do_frame(input logic [31:0] zp, input int ign_at, input int rst_at);
        logic [VW-1:0] obs, expv;
        int k, gk, em, en;
        logic ev, egv, egl, eb, ed;
        start = 1'b1; zparam_in = zp;
        @(posedge clk);
        for (int j = 1; j <= NN + LAT + 1; j++) begin
            @(negedge clk);
            k   = j - 1;
            ev  = (k < NN);
            em  = ev ? coord(k / N) : 0;
            en  = ev ? coord(k % N) : 0;
            gk  = j - 1 - LAT;
            egv = (gk >= 0) && (gk < NN);
            egl = egv && (gk == NN - 1);
            eb  = (j <= NN + LAT);
            ed  = (j == NN + LAT + 1);
            expv = {ev, 10'(em), 10'(en), zp, egv, (egv ? AW'(gk) : {AW{1'b0}}), egl, eb, ed};
            obs  = observed();
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL frame j=%0d got=%h want=%h", j, obs, expv);
            end
            start = 1'b0;
            zparam_in = $urandom;
            if (j == ign_at) begin
                start = 1'b1;
                zparam_in = 32'hFFFFFFFF;
            end
            if (j == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                obs = observed();
                vectors++;
                if (obs !== {VW{1'b0}}) begin
                    miscompares++;
                    $display("FAIL mid_reset got=%h want=%h", obs, {VW{1'b0}});
                end
                rst = 1'b0;
                start = 1'b0;
                idle_cycles(12, 32'd0);
                return;
            end
        end
    endtask

    task automatic test_basic();
        idle_cycles(3, 32'd0);
        do_frame(32'h12345678, 0, 0);
        idle_cycles(2, 32'h12345678);
    endtask

    task automatic test_ignored_inputs();
        do_frame(32'h12345678, 5, 0);
        idle_cycles(1, 32'h12345678);
        do_frame(32'h0BADF00D, NN + LAT, 0);
        idle_cycles(2, 32'h0BADF00D);
    endtask

    task automatic test_back_to_back();
        logic [31:0] zp;
        zp = $urandom;
        do_frame($urandom, 0, 0);
        do_frame(zp, $urandom_range(NN + LAT, 1), 0);
        idle_cycles(2, zp);
    endtask

    task automatic test_reset_mid_frame();
        do_frame($urandom, 0, 8);
        do_frame(32'hA5A5A5A5, 0, NN + 2);
        do_frame(32'h5A5A5A5A, 0, 0);
        idle_cycles(1, 32'h5A5A5A5A);
    endtask

    task automatic test_random_frames();
        logic [31:0] zp;
        int ign, rat;
        for (int f = 0; f < 8; f++) begin
            zp  = $urandom;
            ign = ($urandom_range(1, 0) == 1) ? int'($urandom_range(NN + LAT, 1)) : 0;
            rat = ($urandom_range(3, 0) == 0) ? int'($urandom_range(NN + LAT, 1)) : 0;
            do_frame(zp, ign, rat);
            if (rat == 0 && $urandom_range(1, 0) == 1) begin
                idle_cycles($urandom_range(4, 1), zp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        zparam_in = 32'd0;
        test_reset();
        test_basic();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
